id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
Single-entry pipeline register between decode/register-read and the 16-bit ALU.
- Captures decoded operands, immediate and 4-bit ALU function code.
- Resolves data hazards by forwarding from the EX/MEM and MEM/WB buses.
- Presents registered alu_input_1, alu_input_2 and alu_func_code to the ALU with a valid/ready handshake, stall and flush.

Parameters:
WIDTH, 16, datapath width of operands and forwarded data
IDX_W, 2, register index width (4 architectural registers)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
in_rs1_idx  in  IDX_W  source 1 register index
in_rs2_idx  in  IDX_W  source 2 register index
in_rs1_data  in  WIDTH  register-file read data, source 1
in_rs2_data  in  WIDTH  register-file read data, source 2
in_imm  in  WIDTH  sign/zero-extended immediate, already extended by decode
in_use_imm  in  1  1: operand 2 is in_imm
in_func_code  in  4  ALU function code (ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR encodings)
in_rd_idx  in  IDX_W  destination register
in_reg_write  in  1  instruction writes rd
flush  in  1  synchronous squash of held and incoming instruction
exmem_reg_write  in  1  EX/MEM producer writes a register
exmem_rd_idx  in  IDX_W  EX/MEM destination
exmem_data  in  WIDTH  EX/MEM result
memwb_reg_write  in  1  MEM/WB producer writes a register
memwb_rd_idx  in  IDX_W  MEM/WB destination
memwb_data  in  WIDTH  MEM/WB result
out_valid  out  1  ALU operands valid
out_ready  in  1  downstream accepts this cycle
alu_input_1  out  WIDTH  registered operand 1
alu_input_2  out  WIDTH  registered operand 2 (immediate or forwarded rs2)
alu_func_code  out  4  registered function code
out_rd_idx  out  IDX_W  registered destination
out_reg_write  out  1  registered write enable, qualified by out_valid

Behaviour:
- Reset:
  - reset_n low clears out_valid, alu_input_1, alu_input_2, alu_func_code, out_rd_idx, out_reg_write, and held op2/use_imm/rs indices to 0, immediately (async).
  - Release is synchronous to clk.
  - Reset mid-transfer drops the held instruction; no output glitch to a non-zero value.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid or flush.
- Accept = in_valid && in_ready. Latency is 1 cycle: accepted at edge N, visible at outputs after edge N.
- Operand select at capture, per source s:
  - Use exmem_data if exmem_reg_write && exmem_rd_idx == in_rs_s_idx.
  - Else use memwb_data if memwb_reg_write && memwb_rd_idx == in_rs_s_idx.
  - Else use in_rs_s_data.
  - EX/MEM has priority over MEM/WB.
- alu_input_2 = in_imm when in_use_imm, else the selected rs2 value.
- Hold/refresh: while out_valid && !out_ready, each cycle re-apply the same forwarding priority using the held rs indices.
  - A match overwrites the held operand with the forwarded data.
  - No match leaves the operand unchanged.
  - Operand 2 is never refreshed when the held use_imm = 1.
  - alu_func_code, out_rd_idx and out_reg_write never change while held.
- Advance without new input (out_ready && !accept): out_valid <= 0. Data registers hold their last value (don't-care).
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new instruction is loaded and out_valid stays 1. This gives back-to-back throughput of 1 per cycle.
- flush (highest priority):
  - out_valid <= 0 at the next edge.
  - An instruction handshaked in the same cycle is consumed and discarded.
  - No refresh occurs.
  - flush with out_valid = 0 has no effect beyond the discard.
- No arithmetic is done in this block; all paths are WIDTH-bit with no truncation or extension.
- Index 0 is an ordinary register and is forwarded like any other.

Test Plan:
- Reset: reset_n=0 mid-hold with out_valid=1 -> all outputs 0 before the next clk edge. After release, in_ready=1.
- Basic: in_rs1_data=0x0005, in_rs2_data=0x0003, func=ADD, no fwd match, out_ready=1 -> next cycle out_valid=1, alu_input_1=0x0005, alu_input_2=0x0003.
- Forward priority: in_rs1_idx=2, exmem (write, idx 2, 0x1111) and memwb (write, idx 2, 0x2222) both active at capture -> alu_input_1=0x1111. Same with exmem_reg_write=0 -> 0x2222.
- Immediate: in_use_imm=1, in_imm=0xFFF0, memwb matching rs2 with 0xAAAA during capture and during a 3-cycle stall -> alu_input_2 stays 0xFFF0.
- Stall refresh: capture rs1 idx 1 = 0x0000, hold out_ready=0, then memwb (write, idx 1, 0x00AB) for 1 cycle -> alu_input_1=0x00AB from the following edge, retained until out_ready=1. in_ready=0 throughout the stall.
- Flush/throughput: 3 back-to-back instructions with out_ready=1 -> outputs update every cycle. flush asserted with in_valid=1 -> in_ready=1 and the handshake completes, out_valid=0 next cycle, no instruction emitted.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// Module  : id_ex_operand_stage
// Brief   : ID/EX operand register with EX/MEM and MEM/WB forwarding, and a
//           valid/ready handshake with stall refresh and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_rs1_idx,
  input  logic [IDX_W-1:0] in_rs2_idx,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [3:0]       in_func_code,
  input  logic [IDX_W-1:0] in_rd_idx,
  input  logic             in_reg_write,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [IDX_W-1:0] exmem_rd_idx,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             memwb_reg_write,
  input  logic [IDX_W-1:0] memwb_rd_idx,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_input_1,
  output logic [WIDTH-1:0] alu_input_2,
  output logic [3:0]       alu_func_code,
  output logic [IDX_W-1:0] out_rd_idx,
  output logic             out_reg_write
);

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] op1_q,     op1_d;
  logic [WIDTH-1:0] op2_q,     op2_d;
  logic [3:0]       func_q,    func_d;
  logic [IDX_W-1:0] rd_q,      rd_d;
  logic             regw_q,    regw_d;
  logic             use_imm_q, use_imm_d;
  logic [IDX_W-1:0] rs1_q,     rs1_d;
  logic [IDX_W-1:0] rs2_q,     rs2_d;

  logic             w_accept;
  logic [WIDTH-1:0] w_in_op1;
  logic [WIDTH-1:0] w_in_op2;
  logic [WIDTH-1:0] w_hold_op1;
  logic [WIDTH-1:0] w_hold_op2;

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [IDX_W-1:0] idx,
    input logic [WIDTH-1:0] dflt,
    input logic             em_we,
    input logic [IDX_W-1:0] em_idx,
    input logic [WIDTH-1:0] em_data,
    input logic             mw_we,
    input logic [IDX_W-1:0] mw_idx,
    input logic [WIDTH-1:0] mw_data
  );
    if (em_we && (em_idx == idx)) begin
      return em_data;
    end else if (mw_we && (mw_idx == idx)) begin
      return mw_data;
    end else begin
      return dflt;
    end
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_in_op1 = fwd_sel(in_rs1_idx, in_rs1_data,
                            exmem_reg_write, exmem_rd_idx, exmem_data,
                            memwb_reg_write, memwb_rd_idx, memwb_data);
  assign w_in_op2 = in_use_imm ? in_imm
                  : fwd_sel(in_rs2_idx, in_rs2_data,
                            exmem_reg_write, exmem_rd_idx, exmem_data,
                            memwb_reg_write, memwb_rd_idx, memwb_data);

  // A stalled operand keeps watching the bypass buses so it never goes stale.
  assign w_hold_op1 = fwd_sel(rs1_q, op1_q,
                              exmem_reg_write, exmem_rd_idx, exmem_data,
                              memwb_reg_write, memwb_rd_idx, memwb_data);
  assign w_hold_op2 = use_imm_q ? op2_q
                    : fwd_sel(rs2_q, op2_q,
                              exmem_reg_write, exmem_rd_idx, exmem_data,
                              memwb_reg_write, memwb_rd_idx, memwb_data);

  always_comb begin
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    func_d    = func_q;
    rd_d      = rd_q;
    regw_d    = regw_q;
    use_imm_d = use_imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d   = 1'b1;
      op1_d     = w_in_op1;
      op2_d     = w_in_op2;
      func_d    = in_func_code;
      rd_d      = in_rd_idx;
      regw_d    = in_reg_write;
      use_imm_d = in_use_imm;
      rs1_d     = in_rs1_idx;
      rs2_d     = in_rs2_idx;
    end else if (valid_q && !out_ready) begin
      op1_d = w_hold_op1;
      op2_d = w_hold_op2;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      func_q    <= '0;
      rd_q      <= '0;
      regw_q    <= 1'b0;
      use_imm_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      func_q    <= func_d;
      rd_q      <= rd_d;
      regw_q    <= regw_d;
      use_imm_q <= use_imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  assign out_valid     = valid_q;
  assign alu_input_1   = op1_q;
  assign alu_input_2   = op2_q;
  assign alu_func_code = func_q;
  assign out_rd_idx    = rd_q;
  assign out_reg_write = regw_q && valid_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// Module  : tb_id_ex_operand_stage
// Brief   : Directed self-checking bench for id_ex_operand_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

  localparam int WIDTH = 16;
  localparam int IDX_W = 2;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_rs1_idx;
  logic [IDX_W-1:0] in_rs2_idx;
  logic [WIDTH-1:0] in_rs1_data;
  logic [WIDTH-1:0] in_rs2_data;
  logic [WIDTH-1:0] in_imm;
  logic             in_use_imm;
  logic [3:0]       in_func_code;
  logic [IDX_W-1:0] in_rd_idx;
  logic             in_reg_write;
  logic             flush;
  logic             exmem_reg_write;
  logic [IDX_W-1:0] exmem_rd_idx;
  logic [WIDTH-1:0] exmem_data;
  logic             memwb_reg_write;
  logic [IDX_W-1:0] memwb_rd_idx;
  logic [WIDTH-1:0] memwb_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_input_1;
  logic [WIDTH-1:0] alu_input_2;
  logic [3:0]       alu_func_code;
  logic [IDX_W-1:0] out_rd_idx;
  logic             out_reg_write;

  int tests;
  int fails;

  id_ex_operand_stage #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rs1_idx      (in_rs1_idx),
    .in_rs2_idx      (in_rs2_idx),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .in_imm          (in_imm),
    .in_use_imm      (in_use_imm),
    .in_func_code    (in_func_code),
    .in_rd_idx       (in_rd_idx),
    .in_reg_write    (in_reg_write),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_idx    (exmem_rd_idx),
    .exmem_data      (exmem_data),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_idx    (memwb_rd_idx),
    .memwb_data      (memwb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .alu_input_1     (alu_input_1),
    .alu_input_2     (alu_input_2),
    .alu_func_code   (alu_func_code),
    .out_rd_idx      (out_rd_idx),
    .out_reg_write   (out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IDX_W-1:0] rs1, input logic [WIDTH-1:0] d1,
                      input logic [IDX_W-1:0] rs2, input logic [WIDTH-1:0] d2,
                      input logic [3:0] fc, input logic [IDX_W-1:0] rd);
    in_valid     = 1'b1;
    in_rs1_idx   = rs1;
    in_rs1_data  = d1;
    in_rs2_idx   = rs2;
    in_rs2_data  = d2;
    in_func_code = fc;
    in_rd_idx    = rd;
    in_reg_write = 1'b1;
    in_use_imm   = 1'b0;
    in_imm       = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    in_valid = 0; in_rs1_idx = 0; in_rs2_idx = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_use_imm = 0; in_func_code = 0; in_rd_idx = 0; in_reg_write = 0;
    flush = 0; exmem_reg_write = 0; exmem_rd_idx = 0; exmem_data = 0;
    memwb_reg_write = 0; memwb_rd_idx = 0; memwb_data = 0; out_ready = 1;

    // Reset state
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_in1", alu_input_1, 0);
    chk("rst_in2", alu_input_2, 0);
    chk("rst_func", alu_func_code, 0);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Basic capture, no forwarding
    load(2'd0, 16'h0005, 2'd1, 16'h0003, 4'd0, 2'd3);
    step();
    chk("basic_valid", out_valid, 1);
    chk("basic_in1", alu_input_1, 16'h0005);
    chk("basic_in2", alu_input_2, 16'h0003);
    chk("basic_func", alu_func_code, 4'd0);
    chk("basic_rd", out_rd_idx, 2'd3);
    chk("basic_regw", out_reg_write, 1);
    in_valid = 0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_regw", out_reg_write, 0);

    // Forward priority: EX/MEM beats MEM/WB, then MEM/WB alone
    load(2'd2, 16'h0005, 2'd3, 16'h0007, 4'd1, 2'd2);
    exmem_reg_write = 1; exmem_rd_idx = 2; exmem_data = 16'h1111;
    memwb_reg_write = 1; memwb_rd_idx = 2; memwb_data = 16'h2222;
    step();
    chk("fwd_exmem_in1", alu_input_1, 16'h1111);
    chk("fwd_nomatch_in2", alu_input_2, 16'h0007);
    exmem_reg_write = 0;
    step();
    chk("fwd_memwb_valid", out_valid, 1);
    chk("fwd_memwb_in1", alu_input_1, 16'h2222);

    // Immediate is immune to forwarding at capture and during a stall
    load(2'd0, 16'h0001, 2'd1, 16'h0009, 4'd2, 2'd1);
    in_use_imm = 1; in_imm = 16'hFFF0;
    memwb_reg_write = 1; memwb_rd_idx = 1; memwb_data = 16'hAAAA;
    step();
    chk("imm_cap_in2", alu_input_2, 16'hFFF0);
    chk("imm_cap_in1", alu_input_1, 16'h0001);
    in_valid = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("imm_stall_in2", alu_input_2, 16'hFFF0);
      chk("imm_stall_valid", out_valid, 1);
      chk("imm_stall_in_ready", in_ready, 0);
    end
    memwb_reg_write = 0;
    out_ready = 1;
    step();
    chk("imm_drain_valid", out_valid, 0);

    // Stall refresh of a held operand from MEM/WB
    load(2'd1, 16'h0000, 2'd2, 16'h0042, 4'd6, 2'd1);
    step();
    chk("ref_cap_in1", alu_input_1, 16'h0000);
    in_valid = 0; out_ready = 0;
    #1 chk("ref_in_ready0", in_ready, 0);
    memwb_reg_write = 1; memwb_rd_idx = 1; memwb_data = 16'h00AB;
    step();
    chk("ref_upd_in1", alu_input_1, 16'h00AB);
    chk("ref_upd_in2", alu_input_2, 16'h0042);
    memwb_reg_write = 0;
    step();
    chk("ref_keep_in1", alu_input_1, 16'h00AB);
    chk("ref_keep_func", alu_func_code, 4'd6);
    chk("ref_in_ready1", in_ready, 0);
    // EX/MEM refresh of the held rs2 while still stalled
    exmem_reg_write = 1; exmem_rd_idx = 2; exmem_data = 16'h0BEE;
    step();
    chk("ref_ex_in2", alu_input_2, 16'h0BEE);
    chk("ref_ex_in1", alu_input_1, 16'h00AB);
    exmem_reg_write = 0;
    out_ready = 1;
    step();
    chk("ref_drain_valid", out_valid, 0);

    // Back-to-back throughput
    for (int k = 0; k < 3; k++) begin
      load(2'd0, 16'h0100 + 16'(k), 2'd1, 16'h0200 + 16'(k), 4'(k + 3), 2'd2);
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_in1", alu_input_1, 16'h0100 + 16'(k));
      chk("b2b_in2", alu_input_2, 16'h0200 + 16'(k));
      chk("b2b_func", alu_func_code, 4'(k + 3));
    end

    // Flush while draining and accepting: nothing emitted
    flush = 1;
    #1 chk("flush_in_ready", in_ready, 1);
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_regw", out_reg_write, 0);
    // Flush with nothing held, incoming still discarded
    step();
    chk("flush_idle_valid", out_valid, 0);
    flush = 0;

    // Flush of a held, stalled instruction
    load(2'd3, 16'h7777, 2'd0, 16'h8888, 4'd4, 2'd0);
    step();
    in_valid = 0; out_ready = 0; flush = 1;
    step();
    chk("flush_hold_valid", out_valid, 0);
    flush = 0; out_ready = 1;

    // Asynchronous reset during a stall
    load(2'd1, 16'h1234, 2'd2, 16'h5678, 4'd5, 2'd2);
    step();
    in_valid = 0; out_ready = 0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    reset_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_in1", alu_input_1, 0);
    chk("arst_in2", alu_input_2, 0);
    chk("arst_func", alu_func_code, 0);
    chk("arst_rd", out_rd_idx, 0);
    chk("arst_regw", out_reg_write, 0);
    step();
    reset_n = 1;
    #1 chk("arst_in_ready", in_ready, 1);
    step();
    chk("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
